// File: rtl/kyber_pkg.sv
// Shared types and constants for the Kyber512 operation controller.
package kyber_pkg;

    localparam int unsigned CNT_W  = 10;
    localparam int unsigned MODE_W = 2;
    localparam int unsigned TO_W   = 20;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_PROCESS = 2'd2,
        ST_UNLOAD  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        MODE_KEYGEN  = 2'd0,
        MODE_ENCAPS  = 2'd1,
        MODE_DECAPS  = 2'd2,
        MODE_INVALID = 2'd3
    } mode_e;

    // 32-bit word counts per operation; the invalid slot is never latched
    localparam logic [CNT_W-1:0] IN_WORDS  [4] = '{10'd16,  10'd208, 10'd600, 10'd1};
    localparam logic [CNT_W-1:0] OUT_WORDS [4] = '{10'd608, 10'd200, 10'd8,   10'd1};

endpackage

// File: rtl/kyber_word_cnt.sv
// Word index counter shared by the LOAD and UNLOAD phases.
module kyber_word_cnt
    import kyber_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] term,
    output logic [CNT_W-1:0] cnt,
    output logic             tc_c
);

    // Clear has priority over increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc_c = (cnt == term);

endmodule

// File: rtl/kyber_ctrl.sv
// Kyber512 operation sequencer: load words, kick the core, unload words.
// Define KYBER_CTRL_TIMEOUT_EN to build the PROCESS-phase watchdog.
module kyber_ctrl
    import kyber_pkg::*;
#(
    parameter logic [TO_W-1:0] TIMEOUT_CYCLES = 20'd1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_pulse,
    input  logic              restart_pulse,
    input  logic [MODE_W-1:0] mode,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              core_start,
    output logic [MODE_W-1:0] core_mode,
    input  logic              core_done,
    output logic [1:0]        current_state,
    output logic [CNT_W-1:0]  cnt,
    output logic              done,
    output logic              err
);

    // A zero watchdog limit would underflow the terminal compare
    if (TIMEOUT_CYCLES == '0) begin : g_timeout_chk
        $error("kyber_ctrl: TIMEOUT_CYCLES must be non-zero");
    end

    state_e           state;
    state_e           state_next;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             cnt_tc_c;
    logic [CNT_W-1:0] cnt_term_c;
    logic             mode_load;
    logic             done_set;
    logic             done_clr;
    logic             err_set;
    logic             err_clr;
    logic             timeout_hit_c;

    assign current_state = state;

    // Terminal index depends on which phase owns the counter
    assign cnt_term_c = (state == ST_UNLOAD) ? OUT_WORDS[core_mode] - CNT_W'(1)
                                             : IN_WORDS[core_mode]  - CNT_W'(1);

    kyber_word_cnt u_word_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .term (cnt_term_c),
        .cnt  (cnt),
        .tc_c (cnt_tc_c)
    );

`ifdef KYBER_CTRL_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;

    // Dwell counter: held at zero outside PROCESS so it starts fresh on entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
        end else if (state != ST_PROCESS) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    assign timeout_hit_c = (state == ST_PROCESS) && (to_cnt == TIMEOUT_CYCLES - TO_W'(1));
`else
    assign timeout_hit_c = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode; restart overrides everything
    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        mode_load  = 1'b0;
        done_set   = 1'b0;
        done_clr   = 1'b0;
        err_set    = 1'b0;
        err_clr    = 1'b0;
        if (restart_pulse) begin
            state_next = ST_IDLE;
            cnt_clr    = 1'b1;
            done_clr   = 1'b1;
            err_clr    = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_pulse) begin
                        if (mode != MODE_INVALID) begin
                            mode_load  = 1'b1;
                            done_clr   = 1'b1;
                            err_clr    = 1'b1;
                            cnt_clr    = 1'b1;
                            state_next = ST_LOAD;
                        end else begin
                            err_set = 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (in_valid && in_ready) begin
                        if (cnt_tc_c) begin
                            cnt_clr    = 1'b1;
                            state_next = ST_PROCESS;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end
                end
                ST_PROCESS: begin
                    if (core_done) begin
                        cnt_clr    = 1'b1;
                        state_next = ST_UNLOAD;
                    end else if (timeout_hit_c) begin
                        err_set    = 1'b1;
                        cnt_clr    = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                ST_UNLOAD: begin
                    if (out_valid && out_ready) begin
                        if (cnt_tc_c) begin
                            done_set   = 1'b1;
                            cnt_clr    = 1'b1;
                            state_next = ST_IDLE;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Registered handshakes, core strobe and sticky status
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_mode  <= '0;
            core_start <= 1'b0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (mode_load) begin
                core_mode <= mode;
            end
            core_start <= (state == ST_LOAD) && (state_next == ST_PROCESS);
            in_ready   <= (state_next == ST_LOAD);
            out_valid  <= (state_next == ST_UNLOAD);
            if (done_clr) begin
                done <= 1'b0;
            end else if (done_set) begin
                done <= 1'b1;
            end
            if (err_clr) begin
                err <= 1'b0;
            end else if (err_set) begin
                err <= 1'b1;
            end
        end
    end

endmodule
